// File: rtl/logip_pkg.sv
// Shared types and defaults for the sample capture memory controller.
package logip_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TRIG,
    FETCH,
    SEND
  } mem_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module sdp_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_mem_ctrl.sv
// Ring-buffer capture of packed sample words around a trigger, then newest-first
// read-back over a valid/ready port.
module sample_mem_ctrl
  import logip_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] dly_cnt_i,
  input  logic [CNT_W-1:0] rd_cnt_i,
  input  logic             stb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             tx_stb_o,
  output logic [WIDTH-1:0] tx_d_o,
  input  logic             tx_rdy_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_state_t       state, state_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr, last_addr_c;
  logic [CNT_W-1:0] dly, rd, rd_clamp_c;
  logic             wr_en_c, done_nxt, fetch_lat;
  logic [WIDTH-1:0] ram_q;

  sdp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk_i (clk_i),
    .we    (wr_en_c),
    .waddr (wr_ptr),
    .wdata (d_i),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Next-state, write enable and the newest-word address used when entering FETCH
  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    wr_en_c    = 1'b0;
    rd_clamp_c = (32'(rd_cnt_i) > DEPTH) ? CNT_W'(DEPTH) : rd_cnt_i;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (arm_i) state_nxt = ARMED;
        ARMED: begin
          wr_en_c = stb_i;
          if (run_i) begin
            if (dly_cnt_i != '0)       state_nxt = TRIG;
            else if (rd_clamp_c != '0) state_nxt = FETCH;
            else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        TRIG: begin
          wr_en_c = stb_i;
          if (stb_i && dly == CNT_W'(1)) begin
            if (rd != '0) state_nxt = FETCH;
            else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        FETCH: if (fetch_lat) state_nxt = SEND;
        SEND: begin
          if (tx_stb_o && tx_rdy_i) begin
            if (rd == CNT_W'(1)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = FETCH;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    last_addr_c = wr_en_c ? wr_ptr : wr_ptr - AW'(1);
  end

  // FETCH spends one cycle presenting rd_ptr and one cycle capturing the RAM output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dly       <= '0;
      rd        <= '0;
      fetch_lat <= 1'b0;
      tx_stb_o  <= 1'b0;
      tx_d_o    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_o <= done_nxt;
      busy_o <= (state_nxt != IDLE);
      if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
      if (abort_i) begin
        tx_stb_o  <= 1'b0;
        fetch_lat <= 1'b0;
      end else begin
        case (state)
          IDLE:  if (arm_i) wr_ptr <= '0;
          ARMED: begin
            if (run_i) begin
              dly    <= dly_cnt_i;
              rd     <= rd_clamp_c;
              rd_ptr <= last_addr_c;
            end
          end
          TRIG: begin
            if (stb_i) begin
              dly    <= dly - CNT_W'(1);
              rd_ptr <= wr_ptr;
            end
          end
          FETCH: begin
            fetch_lat <= ~fetch_lat;
            if (fetch_lat) begin
              tx_d_o   <= ram_q;
              tx_stb_o <= 1'b1;
            end
          end
          SEND: begin
            if (tx_stb_o && tx_rdy_i) begin
              tx_stb_o <= 1'b0;
              rd       <= rd - CNT_W'(1);
              rd_ptr   <= rd_ptr - AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
